// File: rtl/operand_fetch.sv
// Decode-side operand fetch: latches an instruction, splits its fields, reads rs/rt from a local
// register array and holds the results behind a valid/ack handshake. Option: OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
   parameter int unsigned DECODE_STAGE = 1,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned REG_COUNT    = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [2:0]            stage,
   input  logic [31:0]           instruction,
   input  logic                  wbWrite,
   input  logic [4:0]            wbAddress,
   input  logic [DATA_WIDTH-1:0] wbData,
   input  logic                  ack,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   output logic [4:0]            rsAddr,
   output logic [4:0]            rtAddr,
   output logic [4:0]            rdAddr,
   output logic [4:0]            shamt,
   output logic [5:0]            opcode,
   output logic [5:0]            funct,
   output logic [31:0]           immExt,
   output logic                  valid,
   output logic                  busy,
   output logic                  overrun
);

   typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

   state_e                  state_q, state_d;
   logic [31:0]             instr_q;
   logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
   logic                    valid_d, overrun_d;
   logic                    latch_en, load_en;
   logic                    req, wr_en;
   logic [4:0]              rs, rt;
   logic [DATA_WIDTH-1:0]   rs_val, rt_val;

   assign req   = (stage == 3'(DECODE_STAGE));
   assign wr_en = wbWrite && (wbAddress != 5'd0) && ({27'd0, wbAddress} < REG_COUNT);
   assign rs    = instr_q[25:21];
   assign rt    = instr_q[20:16];
   assign busy  = (state_q != StIdle);

   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs != 5'd0 && {27'd0, rs} < REG_COUNT) rs_val = regs[rs];
      if (rt != 5'd0 && {27'd0, rt} < REG_COUNT) rt_val = regs[rt];
`ifdef OPERAND_FETCH_BYPASS_EN
      // Forward a write landing on the same edge the operands are loaded.
      if (wr_en && wbAddress == rs) rs_val = wbData;
      if (wr_en && wbAddress == rt) rt_val = wbData;
`endif
   end

   always_comb begin
      state_d   = state_q;
      valid_d   = valid;
      overrun_d = 1'b0;
      latch_en  = 1'b0;
      load_en   = 1'b0;
      case (state_q)
         StIdle: begin
            if (req) begin
               latch_en = 1'b1;
               state_d  = StCapture;
            end
         end
         StCapture: begin
            load_en = 1'b1;
            valid_d = 1'b1;
            state_d = StHold;
         end
         StHold: begin
            if (ack) begin
               valid_d = 1'b0;
               if (req) begin
                  latch_en = 1'b1;
                  state_d  = StCapture;
               end else begin
                  state_d = StIdle;
               end
            end else if (req) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wbAddress] <= wbData;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         instr_q   <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         readData1 <= '0;
         readData2 <= '0;
         rsAddr    <= '0;
         rtAddr    <= '0;
         rdAddr    <= '0;
         shamt     <= '0;
         opcode    <= '0;
         funct     <= '0;
         immExt    <= '0;
      end else begin
         state_q <= state_d;
         valid   <= valid_d;
         overrun <= overrun_d;
         if (latch_en) instr_q <= instruction;
         if (load_en) begin
            readData1 <= rs_val;
            readData2 <= rt_val;
            opcode    <= instr_q[31:26];
            rsAddr    <= instr_q[25:21];
            rtAddr    <= instr_q[20:16];
            rdAddr    <= instr_q[15:11];
            shamt     <= instr_q[10:6];
            funct     <= instr_q[5:0];
            immExt    <= {{16{instr_q[15]}}, instr_q[15:0]};
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the register file and request/hold handshake.
module tb_operand_fetch;
   localparam int unsigned DS = 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  stage = '0;
   logic [31:0] instruction = '0;
   logic        wbWrite = 1'b0;
   logic [4:0]  wbAddress = '0;
   logic [31:0] wbData = '0;
   logic        ack = 1'b0;
   logic [31:0] readData1, readData2, immExt;
   logic [4:0]  rsAddr, rtAddr, rdAddr, shamt;
   logic [5:0]  opcode, funct;
   logic        valid, busy, overrun;

   int unsigned total = 0;
   int unsigned bad = 0;

   always #5 clock = ~clock;

   operand_fetch #(.DECODE_STAGE(DS), .DATA_WIDTH(32), .REG_COUNT(32)) dut (
      .clock(clock), .reset_n(reset_n), .stage(stage), .instruction(instruction),
      .wbWrite(wbWrite), .wbAddress(wbAddress), .wbData(wbData), .ack(ack),
      .readData1(readData1), .readData2(readData2), .rsAddr(rsAddr), .rtAddr(rtAddr),
      .rdAddr(rdAddr), .shamt(shamt), .opcode(opcode), .funct(funct), .immExt(immExt),
      .valid(valid), .busy(busy), .overrun(overrun)
   );

   // Model: register contents, a pending latched instruction, and the presented result.
   logic [31:0] m_regs [32];
   logic [31:0] m_latch, m_shown, m_rd1, m_rd2;
   logic        m_pending, m_presented, m_valid, m_ovr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
      if (wbWrite && wbAddress == a) return wbData;
`endif
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_latch = '0; m_shown = '0; m_rd1 = '0; m_rd2 = '0;
      m_pending = 1'b0; m_presented = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_step();
      logic req;
      req = (stage == 3'(DS));
      m_ovr = 1'b0;
      if (m_pending) begin
         m_shown = m_latch;
         m_rd1 = mread(m_latch[25:21]);
         m_rd2 = mread(m_latch[20:16]);
         m_valid = 1'b1;
         m_pending = 1'b0;
         m_presented = 1'b1;
      end else if (!m_presented) begin
         if (req) begin m_latch = instruction; m_pending = 1'b1; end
      end else if (ack) begin
         m_valid = 1'b0;
         m_presented = 1'b0;
         if (req) begin m_latch = instruction; m_pending = 1'b1; end
      end else if (req) begin
         m_ovr = 1'b1;
      end
      if (wbWrite && wbAddress != 5'd0) m_regs[wbAddress] = wbData;
   endtask

   task automatic check_all();
      logic [31:0] imm;
      imm = {{16{m_shown[15]}}, m_shown[15:0]};
      chk("valid", 32'(valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_pending | m_presented));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("readData1", readData1, m_rd1);
      chk("readData2", readData2, m_rd2);
      chk("opcode", 32'(opcode), 32'(m_shown[31:26]));
      chk("rsAddr", 32'(rsAddr), 32'(m_shown[25:21]));
      chk("rtAddr", 32'(rtAddr), 32'(m_shown[20:16]));
      chk("rdAddr", 32'(rdAddr), 32'(m_shown[15:11]));
      chk("shamt", 32'(shamt), 32'(m_shown[10:6]));
      chk("funct", 32'(funct), 32'(m_shown[5:0]));
      chk("immExt", immExt, imm);
   endtask

   task automatic cycle();
      @(posedge clock);
      if (reset_n) model_step();
      else model_reset();
      @(negedge clock);
      check_all();
   endtask

   initial begin
      model_reset();
      #3;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd1", readData1, 32'd0);
      chk("rst_imm", immExt, 32'd0);
      cycle();
      reset_n = 1'b1;

      // add $10,$8,$9 with reg8 preloaded
      wbWrite = 1'b1; wbAddress = 5'd8; wbData = 32'h0000_00AA;
      cycle();
      wbWrite = 1'b0; stage = 3'(DS); instruction = 32'h0109_5020;
      cycle();
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_valid", 32'(valid), 32'd0);
      stage = 3'd0;
      cycle();
      chk("add_valid", 32'(valid), 32'd1);
      chk("add_rs", 32'(rsAddr), 32'd8);
      chk("add_rt", 32'(rtAddr), 32'd9);
      chk("add_rd", 32'(rdAddr), 32'd10);
      chk("add_funct", 32'(funct), 32'h20);
      chk("add_rd1", readData1, 32'h0000_00AA);
      chk("add_rd2", readData2, 32'd0);

      // addi $8,$0,-4
      ack = 1'b1; cycle();
      chk("ack_idle", 32'(busy), 32'd0);
      ack = 1'b0; stage = 3'(DS); instruction = 32'h2008_FFFC; cycle();
      stage = 3'd0; cycle();
      chk("addi_imm", immExt, 32'hFFFF_FFFC);
      chk("addi_op", 32'(opcode), 32'h08);
      chk("addi_rd1", readData1, 32'd0);
      chk("addi_rd2", readData2, 32'h0000_00AA);

      // Write to register 0 is discarded
      ack = 1'b1; cycle();
      ack = 1'b0; wbWrite = 1'b1; wbAddress = 5'd0; wbData = 32'hDEAD_BEEF; cycle();
      wbWrite = 1'b0; stage = 3'(DS); instruction = 32'h0008_4820; cycle();
      stage = 3'd0; cycle();
      chk("r0_rd1", readData1, 32'd0);

      // Overrun while holding, then ack with a simultaneous request
      stage = 3'(DS); instruction = 32'h012A_5820; cycle();
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_rs_kept", 32'(rsAddr), 32'd0);
      stage = 3'd0; cycle();
      chk("ovr_done", 32'(overrun), 32'd0);
      ack = 1'b1; stage = 3'(DS); cycle();
      chk("rearm_valid", 32'(valid), 32'd0);
      chk("rearm_busy", 32'(busy), 32'd1);
      ack = 1'b0; stage = 3'd0; cycle();
      chk("rearm_valid2", 32'(valid), 32'd1);
      chk("rearm_rs", 32'(rsAddr), 32'd9);
      chk("rearm_rd", 32'(rdAddr), 32'd11);

      // Write-back on the load edge
      ack = 1'b1; cycle();
      ack = 1'b0; stage = 3'(DS); instruction = 32'h0109_5020; cycle();
      stage = 3'd0; wbWrite = 1'b1; wbAddress = 5'd9; wbData = 32'h0000_1234; cycle();
      wbWrite = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
      chk("byp_rd2", readData2, 32'h0000_1234);
`else
      chk("byp_rd2", readData2, 32'd0);
`endif
      ack = 1'b1; cycle();
      ack = 1'b0; stage = 3'(DS); cycle();
      stage = 3'd0; cycle();
      chk("later_rd2", readData2, 32'h0000_1234);

      // Asynchronous reset while holding
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rd1", readData1, 32'd0);
      chk("arst_rd2", readData2, 32'd0);
      chk("arst_rs", 32'(rsAddr), 32'd0);
      model_reset();
      cycle();
      reset_n = 1'b1;
      stage = 3'(DS); cycle();
      stage = 3'd0; cycle();
      chk("post_rst_rd1", readData1, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         stage       = ($urandom_range(0, 3) == 0) ? 3'(DS) : 3'($urandom_range(0, 7));
         instruction = $urandom;
         wbWrite     = 1'($urandom_range(0, 1));
         wbAddress   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wbData      = $urandom;
         ack         = ($urandom_range(0, 9) < 4);
         reset_n     = ($urandom_range(0, 499) != 0);
         cycle();
      end
      reset_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side reader of the architectural register file; the counterpart of the write-back stage that updates registers.
- Captures the instruction word when the multi-cycle stage counter reaches the decode stage.
- Splits the instruction into fields, reads rs/rt from a local register array, and sign-extends the immediate.
- Holds the results stable with a valid/ack handshake until the execute stage consumes them. The register array is updated through a write-back port driven with the same address/data as the write-back stage.

Parameters:
- DECODE_STAGE, 1, stage value that triggers an instruction capture
- DATA_WIDTH, 32, register and data width in bits
- REG_COUNT, 32, number of registers (address width fixed at 5)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stage  in  3  current multi-cycle stage number
- instruction  in  32  instruction word, sampled on capture
- wbWrite  in  1  write-back enable
- wbAddress  in  5  write-back register index
- wbData  in  32  write-back data
- ack  in  1  consumer has taken the operands
- readData1  out  32  value of register rs
- readData2  out  32  value of register rt
- rsAddr, rtAddr, rdAddr  out  5 each  instruction[25:21], [20:16], [15:11]
- shamt  out  5  instruction[10:6]
- opcode  out  6  instruction[31:26]
- funct  out  6  instruction[5:0]
- immExt  out  32  sign-extended instruction[15:0]
- valid  out  1  operands/fields valid
- busy  out  1  FSM not in IDLE
- overrun  out  1  one-cycle pulse: capture request dropped

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0.
  - FSM to IDLE.
  - All REG_COUNT registers cleared to 0.
  - Internal instruction latch cleared to 0.
- Register array:
  - On a rising edge with wbWrite=1 and wbAddress!=0, registers[wbAddress] <= wbData.
  - Writes to register 0 are ignored; register 0 always reads 0.
  - Writes are accepted in every FSM state.
- FSM states IDLE, CAPTURE, HOLD:
  - IDLE: on an edge with stage==DECODE_STAGE, latch instruction into the internal latch and go to CAPTURE. busy=0, valid=0.
  - CAPTURE (exactly one cycle):
    - Drive opcode/rsAddr/rtAddr/rdAddr/shamt/funct/immExt from the latch.
    - Load readData1/readData2 from the array, with rs==0 or rt==0 giving 0.
    - Set valid=1 and go to HOLD.
  - HOLD:
    - All outputs frozen; valid=1.
    - ack=1 at an edge: valid cleared; go to IDLE, or go straight to CAPTURE (latching the new instruction) if stage==DECODE_STAGE on that same edge.
    - stage==DECODE_STAGE with ack=0: the request is dropped, overrun pulses high for one cycle, state remains HOLD.
- Latency: a request sampled at edge N gives valid=1 and stable outputs after edge N+1.
- stage==DECODE_STAGE while in CAPTURE is ignored; it does not set overrun.
- immExt = {16{instruction[15]}, instruction[15:0]}.
- ack while in IDLE or CAPTURE has no effect.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0; the pending instruction is lost.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined: in the CAPTURE cycle, if wbWrite=1 and wbAddress equals a nonzero rs (or rt), the matching readData takes wbData instead of the stale array value. The array is still written normally.
- Undefined: readData takes the pre-write array contents. A write on the same edge is visible only to later captures.

Test Plan:
- Reset, then write reg 8 = 0x0000_00AA; capture instruction 0x0109_5020 (add $10,$8,$9) -> after 2 edges: valid=1, rsAddr=8, rtAddr=9, rdAddr=10, funct=0x20, readData1=0x0000_00AA, readData2=0.
- Capture 0x2008_FFFC (addi $8,$0,-4) -> immExt=0xFFFF_FFFC, opcode=0x08, readData1=0.
- Write reg 0 = 0xDEAD_BEEF, then capture an instruction with rs=0 -> readData1=0.
- In HOLD with ack=0, pulse stage=DECODE_STAGE -> overrun high exactly 1 cycle, outputs unchanged. Then ack=1 with stage=DECODE_STAGE on the same edge -> next instruction's fields valid one edge later.
- wbWrite to reg 9 = 0x1234 on the CAPTURE edge for an instruction with rt=9 -> readData2=0x1234 with OPERAND_FETCH_BYPASS_EN defined, old value without it.
- Assert reset_n low during HOLD -> valid, busy and all outputs 0 immediately, without waiting for a clock edge.
